// File: rtl/fpcsr_sched_pkg.sv
// ---------------------------------------------------------------------------
// fpcsr_sched_pkg
// Shared definitions for the FP CSR commit scheduler and the FP CSR state
// block: CSR index constants, FCSR field positions, the buffered entry
// layout and small helpers that classify an entry.
// XLEN defaults to 64; instantiating modules may override it per instance.
// ---------------------------------------------------------------------------
package fpcsr_sched_pkg;

  localparam int XLEN_DEFAULT = 64;

  localparam logic [11:0] CSR_FFLAGS = 12'h001;
  localparam logic [11:0] CSR_FRM    = 12'h002;
  localparam logic [11:0] CSR_FCSR   = 12'h003;

  // FCSR layout: {frm[2:0], fflags[4:0]}
  localparam int FCSR_FFLAGS_LSB = 0;
  localparam int FCSR_FFLAGS_MSB = 4;
  localparam int FCSR_FRM_LSB    = 5;
  localparam int FCSR_FRM_MSB    = 7;

  // Encoding matches the low two bits of the recognised CSR indices.
  typedef enum logic [1:0] {
    SEL_NONE   = 2'd0,
    SEL_FFLAGS = 2'd1,
    SEL_FRM    = 2'd2,
    SEL_FCSR   = 2'd3
  } csr_sel_e;

  typedef struct packed {
    logic       csren;
    csr_sel_e   csrsel;
    logic [7:0] data;
    logic       fflagen;
    logic [4:0] fflag;
  } entry_t;

  // Builds a buffered entry from one commit slot; unrecognised CSR indices
  // drop the CSR write and leave only the flag accrual (if any).
  function automatic entry_t make_entry(input logic        csren,
                                        input logic [11:0] index,
                                        input logic [7:0]  data,
                                        input logic        fflagen,
                                        input logic [4:0]  fflag);
    entry_t e;
    e = '0;
    if (csren && (index == CSR_FFLAGS || index == CSR_FRM || index == CSR_FCSR)) begin
      e.csren  = 1'b1;
      e.csrsel = csr_sel_e'(index[1:0]);
      e.data   = data;
    end
    if (fflagen) begin
      e.fflagen = 1'b1;
      e.fflag   = fflag;
    end
    return e;
  endfunction

  function automatic logic entry_live(input entry_t e);
    return e.csren || e.fflagen;
  endfunction

  function automatic logic fflag_only(input entry_t e);
    return !e.csren && e.fflagen;
  endfunction

  // Entries that change the rounding mode once drained.
  function automatic logic writes_frm(input entry_t e);
    return e.csren && (e.csrsel == SEL_FRM || e.csrsel == SEL_FCSR);
  endfunction

endpackage

// File: rtl/fpcsr_sched_fifo.sv
// ---------------------------------------------------------------------------
// fpcsr_sched_fifo
// Generic synchronous FIFO with up to two pushes per cycle, one pop per
// cycle, an in-place tail rewrite port and an occupancy count.
// Ports:
//   clk, srst            clock, synchronous active-high reset
//   push[1:0]            push[0] writes push_data0; push[1] (only together
//                        with push[0]) writes push_data1 behind it
//   tail_we, tail_data   overwrite the newest stored entry
//   pop                  remove the head entry (ignored when empty)
//   head, tail           oldest / newest stored entry
//   count                number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module fpcsr_sched_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic [1:0]                 push,
  input  logic [WIDTH-1:0]           push_data0,
  input  logic [WIDTH-1:0]           push_data1,
  input  logic                       tail_we,
  input  logic [WIDTH-1:0]           tail_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [WIDTH-1:0]           tail,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [1:0]       n_push;
  logic             pop_ok;

  assign n_push = {1'b0, push[0]} + {1'b0, push[1]};
  assign pop_ok = pop && (count != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(n_push);
      rd_ptr <= rd_ptr + PW'(pop_ok);
      count  <= count + CW'(n_push) - CW'(pop_ok);
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so
  // stale contents are never observed and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (push[0]) mem[wr_ptr]          <= push_data0;
    if (push[1]) mem[wr_ptr + PW'(1)] <= push_data1;
    if (tail_we) mem[wr_ptr - PW'(1)] <= tail_data;
  end

  assign head = mem[rd_ptr];
  assign tail = mem[wr_ptr - PW'(1)];

endmodule

// File: rtl/fpcsr_commit_sched.sv
// ---------------------------------------------------------------------------
// fpcsr_commit_sched
// Buffers FP side effects from the dual-slot retire stage and drains them,
// one per cycle and in program order, into the single-port FCSR state block.
// FFLAGS/FRM writes are widened into full FCSR images at drain time using
// the live fcsr value, so back-to-back drains compose correctly.
// Ports:
//   clk_i, srst_i                clock, synchronous active-high reset
//   cN_*                         commit slot N (0 older, 1 younger)
//   commit_ready_o               both slots may be accepted this cycle
//   fcsr_i                       current fcsr from the state block
//   fp_valid_o .. fp_fflag_o     update to the state block (FIFO head)
//   frm_pending_o                a buffered entry will change frm
//   fs_dirty_o                   pulse per drained entry
// Build option FPCSR_SCHED_MERGE_EN: coalesce flag-only commits with each
// other and with a flag-only FIFO tail instead of allocating new entries.
// ---------------------------------------------------------------------------
module fpcsr_commit_sched
  import fpcsr_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input  logic            clk_i,
  input  logic            srst_i,
  input  logic            c0_valid_i,
  input  logic            c0_csren_i,
  input  logic [11:0]     c0_csrindex_i,
  input  logic [XLEN-1:0] c0_csrdata_i,
  input  logic            c0_fflagen_i,
  input  logic [4:0]      c0_fflag_i,
  input  logic            c1_valid_i,
  input  logic            c1_csren_i,
  input  logic [11:0]     c1_csrindex_i,
  input  logic [XLEN-1:0] c1_csrdata_i,
  input  logic            c1_fflagen_i,
  input  logic [4:0]      c1_fflag_i,
  output logic            commit_ready_o,
  input  logic [XLEN-1:0] fcsr_i,
  output logic            fp_valid_o,
  output logic            fp_csren_o,
  output logic [11:0]     fp_csrindex_o,
  output logic [XLEN-1:0] fp_csrdata_o,
  output logic            fp_fflagen_o,
  output logic [4:0]      fp_fflag_o,
  output logic            frm_pending_o,
  output logic            fs_dirty_o
);
  localparam int CW = $clog2(DEPTH+1);

  entry_t        e0, e1, push_d0, push_d1, tail_d, head, tail;
  logic          v0, v1, tail_we, pop;
  logic [1:0]    push;
  logic [CW-1:0] count;
  logic [CW-1:0] frm_cnt;
  logic [1:0]    frm_inc;
  logic          frm_dec;

  assign commit_ready_o = count <= CW'(DEPTH - 2);
  assign pop            = count != '0;

  // NOTE: every comb output gets a default first so no path leaves a
  // variable unassigned and infers a latch.
  always_comb begin
    e0      = make_entry(c0_csren_i, c0_csrindex_i, c0_csrdata_i[7:0], c0_fflagen_i, c0_fflag_i);
    e1      = make_entry(c1_csren_i, c1_csrindex_i, c1_csrdata_i[7:0], c1_fflagen_i, c1_fflag_i);
    v0      = c0_valid_i && commit_ready_o && entry_live(e0);
    v1      = c1_valid_i && commit_ready_o && entry_live(e1);
    push    = 2'b00;
    push_d0 = e0;
    push_d1 = e1;
    tail_we = 1'b0;
    tail_d  = tail;
    // Compact surviving slots so push[1] only ever follows push[0].
    if (v0 && v1) begin
      push = 2'b11;
    end else if (v0) begin
      push = 2'b01;
    end else if (v1) begin
      push    = 2'b01;
      push_d0 = e1;
    end
`ifdef FPCSR_SCHED_MERGE_EN
    if (v0 && v1 && fflag_only(e0) && fflag_only(e1)) begin
      push          = 2'b01;
      push_d0.fflag = e0.fflag | e1.fflag;
    end
    // The tail is safe to rewrite only when it is not also the head being
    // drained this cycle, i.e. at least two entries are stored.
    if (push[0] && fflag_only(push_d0) && count >= CW'(2) && fflag_only(tail)) begin
      tail_we      = 1'b1;
      tail_d.fflag = tail.fflag | push_d0.fflag;
      push         = {1'b0, push[1]};
      push_d0      = push_d1;
    end
`endif
  end

  fpcsr_sched_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk_i),
    .srst       (srst_i),
    .push       (push),
    .push_data0 (push_d0),
    .push_data1 (push_d1),
    .tail_we    (tail_we),
    .tail_data  (tail_d),
    .pop        (pop),
    .head       (head),
    .tail       (tail),
    .count      (count)
  );

  // Number of buffered entries that change frm; merged entries are always
  // flag-only, so a tail rewrite never affects this count.
  assign frm_inc = {1'b0, push[0] && writes_frm(push_d0)} + {1'b0, push[1] && writes_frm(push_d1)};
  assign frm_dec = pop && writes_frm(head);

  always_ff @(posedge clk_i) begin
    if (srst_i) frm_cnt <= '0;
    else        frm_cnt <= frm_cnt + CW'(frm_inc) - CW'(frm_dec);
  end

  assign frm_pending_o = frm_cnt != '0;

  always_comb begin
    fp_valid_o    = pop;
    fp_csren_o    = pop && head.csren;
    fp_fflagen_o  = pop && head.fflagen;
    fp_fflag_o    = fp_fflagen_o ? head.fflag : 5'd0;
    fp_csrindex_o = fp_csren_o ? CSR_FCSR : 12'h000;
    fp_csrdata_o  = '0;
    if (fp_csren_o) begin
      case (head.csrsel)
        SEL_FFLAGS: fp_csrdata_o[7:0] = {fcsr_i[FCSR_FRM_MSB:FCSR_FRM_LSB], head.data[FCSR_FFLAGS_MSB:0]};
        SEL_FRM:    fp_csrdata_o[7:0] = {head.data[2:0], fcsr_i[FCSR_FFLAGS_MSB:FCSR_FFLAGS_LSB]};
        default:    fp_csrdata_o[7:0] = head.data;
      endcase
    end
  end

  assign fs_dirty_o = fp_valid_o;

  // Upper data bits are architecturally unused; the tail is only consumed
  // by the merge build.
  logic unused_bits;
  assign unused_bits = ^{fcsr_i[XLEN-1:8], c0_csrdata_i[XLEN-1:8], c1_csrdata_i[XLEN-1:8], tail};

endmodule

// File: doc/fpcsr_commit_sched.md
Name: fpcsr_commit_sched

Overview:
- Schedules FP commit traffic from the dual-slot retire stage into the single-port FP CSR state block (fcsr holder).
- Buffers up to DEPTH entries and drains one entry per cycle, in program order.
- Translates FFLAGS/FRM writes into full FCSR writes using the current fcsr value.
- Flags pending rounding-mode writes so decode can stall dynamic-rounding FP ops.

Parameters:
DEPTH, 4, buffer entries (power of 2, >=2)
XLEN, `XLEN, data width (64)

Ports:
clk_i  in  1  clock
srst_i  in  1  synchronous active-high reset
cN_valid_i  in  1  commit slot N (N=0 older, 1 younger) carries FP side effect
cN_csren_i  in  1  slot N is an FP CSR write
cN_csrindex_i  in  12  slot N CSR index
cN_csrdata_i  in  XLEN  slot N CSR write data
cN_fflagen_i  in  1  slot N accrues fflags
cN_fflag_i  in  5  slot N flags {NV,DZ,OF,UF,NX}
commit_ready_o  out  1  both slots may be accepted this cycle
fcsr_i  in  XLEN  current fcsr from the state block
fp_valid_o  out  1  update strobe to state block
fp_csren_o  out  1  FCSR write
fp_csrindex_o  out  12  always FCSR index when fp_csren_o
fp_csrdata_o  out  XLEN  full FCSR image
fp_fflagen_o  out  1  accrue flags
fp_fflag_o  out  5  flags to OR in
frm_pending_o  out  1  a buffered entry writes FRM or FCSR
fs_dirty_o  out  1  one-cycle pulse per drained entry

Behaviour:
- Reset, synchronous, active-high: FIFO empty (wr_ptr=rd_ptr=0, count=0). All outputs 0 except commit_ready_o=1. srst_i mid-operation discards buffered entries.
- Accept: a slot is enqueued when cN_valid_i && commit_ready_o. commit_ready_o = (DEPTH - count) >= 2, registered-count based. Retire must not present valid while commit_ready_o=0; input is ignored in that case. Slot0 is enqueued before slot1. Both valid -> +2 entries; one valid -> +1.
- Recognised CSR indices are 0x001 FFLAGS, 0x002 FRM and 0x003 FCSR. For any other index, csren is ignored and the entry is treated as fflag-only. An entry with neither effect after this filtering is not enqueued.
- Drain: when count>0, fp_valid_o=1 combinationally from the FIFO head. Exactly one entry is popped per cycle, with no backpressure from the state block.
- Translation happens at drain time, using fcsr_i:
  - FFLAGS: data = {fcsr_i[7:5], csrdata[4:0]}.
  - FRM: data = {csrdata[2:0], fcsr_i[4:0]}.
  - FCSR: data = csrdata[7:0].
  - Upper bits are zero-extended.
  - fcsr_i reflects the previous pop on the next edge, so back-to-back pops stay correct.
- An entry with both csren and fflagen drives both outputs; the state block gives the CSR write priority.
- Simultaneous enqueue and pop: count = count + enq - pop.
- Pointers wrap modulo DEPTH.
- Full: count can reach DEPTH; commit_ready_o=0 at count > DEPTH-2.
- frm_pending_o = OR over valid entries of (csren && index in {FRM, FCSR}). It is registered-state derived and does not include the same-cycle input.
- fs_dirty_o = fp_valid_o.
- No flush input: entries are architecturally committed.

Optional Feature:
FPCSR_SCHED_MERGE_EN
- Defined: when both slots are valid and both are fflag-only, they enqueue as one entry with fflag = c0|c1.
- Also defined: a fflag-only enqueue merges into the FIFO tail if the tail is fflag-only and is not being popped this cycle; no new entry is allocated.
- Undefined: no merging; one entry per valid slot.
- commit_ready_o rule is unchanged in both builds.

Decomposition:
- Shared package fpcsr_sched_pkg holds:
  - the entry struct (csren, csrsel[1:0] = FFLAGS/FRM/FCSR, data[7:0], fflagen, fflag[4:0]);
  - CSR index constants;
  - FCSR bit-position constants shared with the state block.
- Only 8 data bits are buffered.
- One sub-module: fpcsr_sched_fifo, a generic synchronous FIFO with count output. Translation, merging and frm_pending logic stay in the top.

Test Plan:
1. Reset, then c0 FRM write of 0x4 with fcsr_i=0x01 → next cycle: fp_valid_o=1, fp_csrdata_o=0x81, fp_csrindex_o=0x003, frm_pending_o=1 during the buffered cycle, fs_dirty_o=1 for one cycle.
2. Both slots fflag-only (c0=0x01 NX, c1=0x10 NV):
   - merge defined → one pop with fflag=0x11;
   - undefined → two pops, 0x01 then 0x10.
3. Fill: 2 valid slots every cycle, fp pops 1 per cycle, DEPTH=4 → commit_ready_o drops to 0 when count≥3; no entry lost; pop order matches commit order.
4. c0 FFLAGS write 0x1F followed by c1 FRM write 0x2, fcsr_i updated per pop → pops 0x1F (with fcsr_i[7:5]) then {0x2, 0x1F}.
5. CSR index 0x300 with csren and fflagen=0 → nothing enqueued, fp_valid_o stays 0.
6. srst_i asserted with 3 entries buffered → next cycle count=0, fp_valid_o=0, frm_pending_o=0, commit_ready_o=1.
